dual_issue_scheduler: RTL and testbench
=======================================

Name: dual_issue_scheduler

Overview:
In-order dual-issue scheduler between the fetch/decode stage and the even/odd pipe pair. It accepts an ordered, pre-decoded instruction pair (A older, B younger). Each cycle it routes the instructions to the even or odd pipe slot, or splits or stalls the pair on structural or data hazards. A per-register latency scoreboard tracks in-flight writes, and a branch flush discards unissued work.

Parameters:
LAT_W, 3, width of per-register latency counter; max latency 2^LAT_W-1
NOP_EVEN, 32'h40200000, encoding placed in even slot when idle
NOP_ODD, 32'h00200000, encoding (lnop) placed in odd slot when idle

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
fetch_valid  in  1  pair presented
fetch_ready  out  1  pair consumed this cycle
a_instr, b_instr  in  32 each  raw instruction words
b_valid  in  1  B slot holds a real instruction
a_odd, b_odd  in  1 each  pipe class: 0 even, 1 odd
a_rt, b_rt  in  7 each  destination register
a_we, b_we  in  1 each  writes rt
a_src0..2, b_src0..2  in  7 each  source registers (ra, rb, rc)
a_use, b_use  in  3 each  per-source valid mask
a_lat, b_lat  in  LAT_W each  cycles until rt writeback
flush  in  1  branch taken; discard unissued work
instr_even, instr_odd  out  32 each  registered issue words to pipes
issue_count  out  2  instructions issued (registered, 0..2)

Behaviour:
- Reset (reset=0, async):
  - instr_even=NOP_EVEN, instr_odd=NOP_ODD, issue_count=0.
  - State RUN, all scoreboard counters 0, holding register empty.
- Scoreboard:
  - 128 counters; every cycle a nonzero counter decrements by 1.
  - On issue with we=1: cnt[rt] <= max(cnt[rt]-1 saturating at 0, lat).
  - Register source hazard: cnt[src]!=0 for any src enabled in the use mask.
- State RUN, head = A:
  - A blocked (source hazard) or fetch_valid=0: issue NOPs in both slots; fetch_ready=0.
  - Else fetch_ready=1 and A goes to its class slot.
  - B also issues in the same cycle iff all of:
    - b_valid
    - b_odd != a_odd
    - no B source equals a_rt while a_we
    - not (a_we && b_we && a_rt==b_rt)
    - no scoreboard hazard on B
  - If B does not issue and b_valid: B fields are captured into the holding register; next state HOLD.
  - The unused slot receives its NOP.
- State HOLD, head = held B:
  - fetch_ready=0.
  - Issues alone once its scoreboard hazard clears (A's scoreboard entry already set); next state RUN.
  - Never pairs with the next fetch.
- Latency: issue words appear on instr_even/instr_odd the cycle after the decision (registered). issue_count updates with them.
- flush (highest priority):
  - Both slots NOP next cycle; fetch_ready=0 that cycle.
  - Holding register cleared; state RUN.
  - Scoreboard keeps counting (in-flight writes still complete).
- Simultaneous flush and hazard clear in HOLD: flush wins; held B is dropped.
- Same-cycle decrement and set on one register: set value per max rule above.
- lat=0 with we=1: no scoreboard entry created.

Optional Feature:
- Macro: SCHED_STATS_EN.
- When defined:
  - Adds three 32-bit outputs: stat_dual, stat_single, stat_stall. They count cycles issuing 2, 1 and 0 instructions (stall counted only when fetch_valid=1 or state HOLD).
  - Counters reset to 0 and wrap at 2^32.
  - Flush cycles are not counted.
- When undefined: ports and counters absent; core behaviour identical.

Test Plan:
- A=even add r3 (lat 2), B=odd lqd r4, independent, all counters 0 → next cycle instr_even=A, instr_odd=B, issue_count=2, fetch_ready was 1.
- A and B both even (a r3 / ah r5), independent → cycle1: instr_even=A, instr_odd=NOP_ODD, count 1; cycle2: instr_even=B, count 1, state back to RUN.
- A writes r3 lat 4, B odd reads r3 → B held; B issues only after cnt[r3] reaches 0 (4 cycles after A's issue), NOPs in between.
- flush asserted while in HOLD → next cycle both NOP, B never appears, fetch_ready=1 the following cycle.
- A writes r7 lat 3, B writes r7 (different pipes) → split; cnt[r7] takes B's value on B's issue.
- reset asserted mid-HOLD → outputs immediately NOP_EVEN/NOP_ODD, count 0, scoreboard cleared. With SCHED_STATS_EN, stat counters read 0.

Source files
------------

// File: rtl/dual_issue_scheduler_if.sv
// Fetch-side instruction pair and registered issue words shared between
// dual_issue_scheduler (slave) and whatever drives it (master).
interface dual_issue_scheduler_if #(
   parameter int LAT_W = 3
);
   logic             fetch_valid;
   logic             fetch_ready;
   logic [31:0]      a_instr;
   logic [31:0]      b_instr;
   logic             b_valid;
   logic             a_odd;
   logic             b_odd;
   logic [6:0]       a_rt;
   logic [6:0]       b_rt;
   logic             a_we;
   logic             b_we;
   logic [6:0]       a_src0;
   logic [6:0]       a_src1;
   logic [6:0]       a_src2;
   logic [6:0]       b_src0;
   logic [6:0]       b_src1;
   logic [6:0]       b_src2;
   logic [2:0]       a_use;
   logic [2:0]       b_use;
   logic [LAT_W-1:0] a_lat;
   logic [LAT_W-1:0] b_lat;
   logic             flush;
   logic [31:0]      instr_even;
   logic [31:0]      instr_odd;
   logic [1:0]       issue_count;

   modport master (
      output fetch_valid, a_instr, b_instr, b_valid, a_odd, b_odd, a_rt, b_rt,
             a_we, b_we, a_src0, a_src1, a_src2, b_src0, b_src1, b_src2,
             a_use, b_use, a_lat, b_lat, flush,
      input  fetch_ready, instr_even, instr_odd, issue_count
   );

   modport slave (
      input  fetch_valid, a_instr, b_instr, b_valid, a_odd, b_odd, a_rt, b_rt,
             a_we, b_we, a_src0, a_src1, a_src2, b_src0, b_src1, b_src2,
             a_use, b_use, a_lat, b_lat, flush,
      output fetch_ready, instr_even, instr_odd, issue_count
   );
endinterface

// File: rtl/dual_issue_scheduler.sv
// In-order dual-issue scheduler with per-register latency scoreboard and a one-entry
// holding register for a split B. Define SCHED_STATS_EN to add issue statistics counters.
module dual_issue_scheduler #(
   parameter int          LAT_W    = 3,
   parameter logic [31:0] NOP_EVEN = 32'h40200000,
   parameter logic [31:0] NOP_ODD  = 32'h00200000
) (
   input  logic                  clk,
   input  logic                  reset,
   dual_issue_scheduler_if.slave bus
`ifdef SCHED_STATS_EN
   ,
   output logic [31:0]           stat_dual,
   output logic [31:0]           stat_single,
   output logic [31:0]           stat_stall
`endif
);

   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;

   typedef logic [LAT_W-1:0] lat_t;

   typedef struct packed {
      logic [31:0] instr;
      logic        odd;
      logic [6:0]  rt;
      logic        we;
      logic [6:0]  src0;
      logic [6:0]  src1;
      logic [6:0]  src2;
      logic [2:0]  use_m;
      lat_t        lat;
   } held_t;

   lat_t        cnt_q   [128];
   lat_t        cnt_d   [128];
   lat_t        cnt_dec [128];
   logic [0:0]  state_q, state_d;
   held_t       held_q, held_d;
   logic [31:0] even_q, even_d;
   logic [31:0] odd_q, odd_d;
   logic [1:0]  count_q, count_d;
   logic        fetch_ready;
   logic        a_haz, b_haz, h_haz, b_fwd, b_pair;

   function automatic logic src_busy(input logic [6:0] s0, input logic [6:0] s1,
                                     input logic [6:0] s2, input logic [2:0] use_m);
      return (use_m[0] && (cnt_q[s0] != '0)) ||
             (use_m[1] && (cnt_q[s1] != '0)) ||
             (use_m[2] && (cnt_q[s2] != '0));
   endfunction

   function automatic lat_t lat_max(input lat_t cur, input lat_t lat);
      return (lat > cur) ? lat : cur;
   endfunction

   always_comb begin
      for (int i = 0; i < 128; i++) begin
         cnt_dec[i] = (cnt_q[i] != '0) ? cnt_q[i] - lat_t'(1) : '0;
      end
   end

   // B may pair with A only if it is in the other pipe and neither reads nor overwrites A's result.
   always_comb begin
      a_haz  = src_busy(bus.a_src0, bus.a_src1, bus.a_src2, bus.a_use);
      b_haz  = src_busy(bus.b_src0, bus.b_src1, bus.b_src2, bus.b_use);
      h_haz  = src_busy(held_q.src0, held_q.src1, held_q.src2, held_q.use_m);
      b_fwd  = bus.a_we && ((bus.b_use[0] && (bus.b_src0 == bus.a_rt)) ||
                            (bus.b_use[1] && (bus.b_src1 == bus.a_rt)) ||
                            (bus.b_use[2] && (bus.b_src2 == bus.a_rt)));
      b_pair = bus.b_valid && (bus.b_odd != bus.a_odd) && !b_fwd &&
               !(bus.a_we && bus.b_we && (bus.a_rt == bus.b_rt)) && !b_haz;
   end

   always_comb begin
      state_d     = state_q;
      held_d      = held_q;
      even_d      = NOP_EVEN;
      odd_d       = NOP_ODD;
      count_d     = 2'd0;
      fetch_ready = 1'b0;
      cnt_d       = cnt_dec;
      if (bus.flush) begin
         state_d = ST_RUN;
         held_d  = '0;
      end else if (state_q == ST_HOLD) begin
         if (!h_haz) begin
            if (held_q.odd) odd_d = held_q.instr;
            else            even_d = held_q.instr;
            count_d = 2'd1;
            state_d = ST_RUN;
            held_d  = '0;
            if (held_q.we) cnt_d[held_q.rt] = lat_max(cnt_dec[held_q.rt], held_q.lat);
         end
      end else if (bus.fetch_valid && !a_haz) begin
         fetch_ready = 1'b1;
         count_d     = 2'd1;
         if (bus.a_odd) odd_d = bus.a_instr;
         else           even_d = bus.a_instr;
         if (bus.a_we) cnt_d[bus.a_rt] = lat_max(cnt_dec[bus.a_rt], bus.a_lat);
         if (b_pair) begin
            count_d = 2'd2;
            if (bus.b_odd) odd_d = bus.b_instr;
            else           even_d = bus.b_instr;
            if (bus.b_we) cnt_d[bus.b_rt] = lat_max(cnt_dec[bus.b_rt], bus.b_lat);
         end else if (bus.b_valid) begin
            state_d = ST_HOLD;
            held_d  = '{instr: bus.b_instr, odd: bus.b_odd, rt: bus.b_rt, we: bus.b_we,
                        src0: bus.b_src0, src1: bus.b_src1, src2: bus.b_src2,
                        use_m: bus.b_use, lat: bus.b_lat};
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_RUN;
         held_q  <= '0;
         even_q  <= NOP_EVEN;
         odd_q   <= NOP_ODD;
         count_q <= 2'd0;
         for (int i = 0; i < 128; i++) cnt_q[i] <= '0;
      end else begin
         state_q <= state_d;
         held_q  <= held_d;
         even_q  <= even_d;
         odd_q   <= odd_d;
         count_q <= count_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.fetch_ready = fetch_ready;
   assign bus.instr_even  = even_q;
   assign bus.instr_odd   = odd_q;
   assign bus.issue_count = count_q;

`ifdef SCHED_STATS_EN
   logic [31:0] stat_dual_q, stat_dual_d;
   logic [31:0] stat_single_q, stat_single_d;
   logic [31:0] stat_stall_q, stat_stall_d;

   // Idle cycles with nothing presented are not stalls; flush cycles are ignored entirely.
   always_comb begin
      stat_dual_d   = stat_dual_q;
      stat_single_d = stat_single_q;
      stat_stall_d  = stat_stall_q;
      if (!bus.flush) begin
         case (count_d)
            2'd2:    stat_dual_d   = stat_dual_q + 32'd1;
            2'd1:    stat_single_d = stat_single_q + 32'd1;
            default: if (bus.fetch_valid || (state_q == ST_HOLD))
                        stat_stall_d = stat_stall_q + 32'd1;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_dual_q   <= '0;
         stat_single_q <= '0;
         stat_stall_q  <= '0;
      end else begin
         stat_dual_q   <= stat_dual_d;
         stat_single_q <= stat_single_d;
         stat_stall_q  <= stat_stall_d;
      end
   end

   assign stat_dual   = stat_dual_q;
   assign stat_single = stat_single_q;
   assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Self-checking bench for dual_issue_scheduler: a vector table for single-pair routing
// plus hand-written sequences for hold, flush, WAW scoreboard and mid-hold reset.
module tb_dual_issue_scheduler;

   localparam logic [31:0] NE = 32'h40200000;
   localparam logic [31:0] NO = 32'h00200000;

   typedef struct packed {
      logic [31:0] a_instr;
      logic [31:0] b_instr;
      logic        b_valid;
      logic        a_odd;
      logic        b_odd;
      logic [6:0]  a_rt;
      logic [6:0]  b_rt;
      logic        a_we;
      logic        b_we;
      logic [6:0]  a_s0;
      logic [6:0]  b_s0;
      logic [6:0]  b_s2;
      logic [2:0]  a_use;
      logic [2:0]  b_use;
      logic [2:0]  a_lat;
      logic [2:0]  b_lat;
      logic        exp_ready;
      logic [31:0] e_even1;
      logic [31:0] e_odd1;
      logic [1:0]  e_cnt1;
      logic [31:0] e_even2;
      logic [31:0] e_odd2;
      logic [1:0]  e_cnt2;
   } vec_t;

   typedef struct packed {
      logic [31:0] even;
      logic [31:0] odd;
      logic [1:0]  cnt;
   } out_t;

   logic clk;
   logic reset;
   int   checks;
   int   failures;
   out_t exp_q [$];
   vec_t vecs [9];
   vec_t idle;
   vec_t v;

   dual_issue_scheduler_if #(.LAT_W(3)) bus ();

   dual_issue_scheduler dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic vec_t mk(input logic [31:0] ai, input logic [31:0] bi, input logic bv,
                               input logic ao, input logic bo, input logic [6:0] art,
                               input logic [6:0] brt, input logic awe, input logic bwe,
                               input logic [6:0] as0, input logic [2:0] ause,
                               input logic [6:0] bs0, input logic [6:0] bs2,
                               input logic [2:0] buse, input logic [2:0] alat,
                               input logic [2:0] blat);
      vec_t r;
      r = '0;
      r.a_instr = ai;  r.b_instr = bi;  r.b_valid = bv;
      r.a_odd   = ao;  r.b_odd   = bo;  r.a_rt    = art;  r.b_rt = brt;
      r.a_we    = awe; r.b_we    = bwe; r.a_s0    = as0;  r.a_use = ause;
      r.b_s0    = bs0; r.b_s2    = bs2; r.b_use   = buse;
      r.a_lat   = alat; r.b_lat  = blat;
      return r;
   endfunction

   function automatic vec_t withExp(input vec_t r0, input logic er,
                                    input logic [31:0] e1, input logic [31:0] o1,
                                    input logic [1:0] c1, input logic [31:0] e2,
                                    input logic [31:0] o2, input logic [1:0] c2);
      vec_t r;
      r = r0;
      r.exp_ready = er;
      r.e_even1 = e1; r.e_odd1 = o1; r.e_cnt1 = c1;
      r.e_even2 = e2; r.e_odd2 = o2; r.e_cnt2 = c2;
      return r;
   endfunction

   task automatic applyStimulus(input vec_t s, input logic fv, input logic fl);
      bus.fetch_valid = fv;
      bus.flush       = fl;
      bus.a_instr     = s.a_instr;
      bus.b_instr     = s.b_instr;
      bus.b_valid     = s.b_valid;
      bus.a_odd       = s.a_odd;
      bus.b_odd       = s.b_odd;
      bus.a_rt        = s.a_rt;
      bus.b_rt        = s.b_rt;
      bus.a_we        = s.a_we;
      bus.b_we        = s.b_we;
      bus.a_src0      = s.a_s0;
      bus.a_src1      = 7'd0;
      bus.a_src2      = 7'd0;
      bus.b_src0      = s.b_s0;
      bus.b_src1      = 7'd0;
      bus.b_src2      = s.b_s2;
      bus.a_use       = s.a_use;
      bus.b_use       = s.b_use;
      bus.a_lat       = s.a_lat;
      bus.b_lat       = s.b_lat;
   endtask

   task automatic pushExp(input logic [31:0] e, input logic [31:0] o, input logic [1:0] c);
      out_t x;
      x.even = e; x.odd = o; x.cnt = c;
      exp_q.push_back(x);
   endtask

   task automatic checkOutput(input string name);
      out_t x;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("[TB] FAIL %s: no expected entry queued", name);
      end else begin
         x = exp_q.pop_front();
         if (bus.instr_even !== x.even || bus.instr_odd !== x.odd || bus.issue_count !== x.cnt) begin
            failures++;
            $display("[TB] FAIL %s: got even=%h odd=%h cnt=%0d, want even=%h odd=%h cnt=%0d",
                     name, bus.instr_even, bus.instr_odd, bus.issue_count, x.even, x.odd, x.cnt);
         end
      end
   endtask

   task automatic checkReady(input string name, input logic exp);
      #1;
      checks++;
      if (bus.fetch_ready !== exp) begin
         failures++;
         $display("[TB] FAIL %s: fetch_ready got %b want %b", name, bus.fetch_ready, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int n);
      applyStimulus(idle, 1'b0, 1'b0);
      for (int k = 0; k < n; k++) begin
         pushExp(NE, NO, 2'd0);
         step();
         checkOutput("drain_nop");
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      idle     = '0;

      vecs[0] = withExp(mk(32'h18000203, 32'h34000304, 1, 0, 1, 7'd3, 7'd4, 1, 1, 0, 0, 7'd1, 0, 3'b001, 3'd2, 3'd6),
                        1, 32'h18000203, 32'h34000304, 2, NE, NO, 0);
      vecs[1] = withExp(mk(32'hA1A1A1A1, 32'hB1B1B1B1, 1, 1, 0, 7'd5, 7'd0, 1, 0, 0, 0, 7'd6, 0, 3'b001, 3'd1, 3'd0),
                        1, 32'hB1B1B1B1, 32'hA1A1A1A1, 2, NE, NO, 0);
      vecs[2] = withExp(mk(32'h18000A03, 32'h19000B05, 1, 0, 0, 7'd3, 7'd5, 1, 1, 0, 0, 7'd8, 0, 3'b001, 3'd1, 3'd1),
                        1, 32'h18000A03, NO, 1, 32'h19000B05, NO, 1);
      vecs[3] = withExp(mk(32'hA3A3A3A3, 32'hB3B3B3B3, 1, 1, 1, 7'd20, 7'd21, 1, 1, 0, 0, 7'd0, 0, 3'b000, 3'd0, 3'd0),
                        1, NE, 32'hA3A3A3A3, 1, NE, 32'hB3B3B3B3, 1);
      vecs[4] = withExp(mk(32'hA4A4A4A4, 32'hB4B4B4B4, 0, 1, 0, 7'd22, 7'd23, 0, 0, 0, 0, 7'd0, 0, 3'b000, 3'd0, 3'd0),
                        1, NE, 32'hA4A4A4A4, 1, NE, NO, 0);
      vecs[5] = withExp(mk(32'hA5A5A5A5, 32'hB5B5B5B5, 1, 0, 1, 7'd10, 7'd24, 1, 0, 0, 0, 7'd0, 7'd10, 3'b100, 3'd0, 3'd0),
                        1, 32'hA5A5A5A5, NO, 1, NE, 32'hB5B5B5B5, 1);
      vecs[6] = withExp(mk(32'hA6A6A6A6, 32'hB6B6B6B6, 1, 1, 0, 7'd11, 7'd11, 1, 1, 0, 0, 7'd0, 0, 3'b000, 3'd0, 3'd0),
                        1, NE, 32'hA6A6A6A6, 1, 32'hB6B6B6B6, NO, 1);
      vecs[7] = withExp(mk(32'hA7A7A7A7, 32'hB7B7B7B7, 1, 0, 1, 7'd10, 7'd25, 1, 0, 0, 0, 7'd1, 7'd10, 3'b001, 3'd0, 3'd0),
                        1, 32'hA7A7A7A7, 32'hB7B7B7B7, 2, NE, NO, 0);
      vecs[8] = withExp(mk(32'hA8A8A8A8, 32'hB8B8B8B8, 1, 0, 1, 7'd12, 7'd26, 0, 0, 0, 0, 7'd12, 0, 3'b001, 3'd0, 3'd0),
                        1, 32'hA8A8A8A8, 32'hB8B8B8B8, 2, NE, NO, 0);

      // Reset state, checked while reset is still asserted
      reset = 1'b0;
      applyStimulus(idle, 1'b0, 1'b0);
      #12;
      pushExp(NE, NO, 2'd0);
      checkOutput("reset_state");
      reset = 1'b1;
      step();

      // Table vectors: one pair each, then a drain so every counter is back to 0
      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i], 1'b1, 1'b0);
         checkReady($sformatf("v%0d_ready", i), vecs[i].exp_ready);
         pushExp(vecs[i].e_even1, vecs[i].e_odd1, vecs[i].e_cnt1);
         step();
         checkOutput($sformatf("v%0d_cycle1", i));
         applyStimulus(idle, 1'b0, 1'b0);
         pushExp(vecs[i].e_even2, vecs[i].e_odd2, vecs[i].e_cnt2);
         step();
         checkOutput($sformatf("v%0d_cycle2", i));
         drain(7);
      end

      // RAW through scoreboard: A writes r3 lat 4, B reads r3, B held until cnt[r3] is 0
      v = mk(32'h1C000303, 32'h3C000400, 1, 0, 1, 7'd3, 7'd40, 1, 0, 0, 0, 7'd3, 0, 3'b001, 3'd4, 3'd0);
      applyStimulus(v, 1'b1, 1'b0);
      checkReady("raw_a_ready", 1'b1);
      pushExp(32'h1C000303, NO, 2'd1);
      step();
      checkOutput("raw_a_issue");
      v = mk(32'hC0C0C0C0, 32'hD0D0D0D0, 1, 0, 1, 7'd50, 7'd51, 0, 0, 0, 0, 7'd0, 0, 3'b000, 3'd0, 3'd0);
      applyStimulus(v, 1'b1, 1'b0);
      checkReady("hold_blocks_fetch", 1'b0);
      pushExp(NE, NO, 2'd0);
      step();
      checkOutput("raw_hold_wait1");
      applyStimulus(idle, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         pushExp(NE, NO, 2'd0);
         step();
         checkOutput($sformatf("raw_hold_wait%0d", k + 2));
      end
      pushExp(NE, 32'h3C000400, 2'd1);
      step();
      checkOutput("raw_b_issue");
      drain(2);

      // Flush while holding B: B is dropped, next pair accepted right after
      v = mk(32'hE1E1E1E1, 32'hE2E2E2E2, 1, 0, 0, 7'd30, 7'd31, 1, 1, 0, 0, 7'd0, 0, 3'b000, 3'd0, 3'd0);
      applyStimulus(v, 1'b1, 1'b0);
      pushExp(32'hE1E1E1E1, NO, 2'd1);
      step();
      checkOutput("flush_a_issue");
      applyStimulus(idle, 1'b0, 1'b1);
      pushExp(NE, NO, 2'd0);
      step();
      checkOutput("flush_drops_b");
      v = mk(32'hE3E3E3E3, 32'hE4E4E4E4, 1, 0, 1, 7'd32, 7'd33, 0, 0, 0, 0, 7'd0, 0, 3'b000, 3'd0, 3'd0);
      applyStimulus(v, 1'b1, 1'b0);
      checkReady("after_flush_ready", 1'b1);
      pushExp(32'hE3E3E3E3, 32'hE4E4E4E4, 2'd2);
      step();
      checkOutput("after_flush_pair");
      v = mk(32'hE5E5E5E5, 32'hE6E6E6E6, 1, 0, 1, 7'd34, 7'd35, 0, 0, 0, 0, 7'd0, 0, 3'b000, 3'd0, 3'd0);
      applyStimulus(v, 1'b1, 1'b1);
      checkReady("flush_run_ready", 1'b0);
      pushExp(NE, NO, 2'd0);
      step();
      checkOutput("flush_run_nop");
      drain(2);

      // WAW on r7: B's longer latency must win, so a reader of r7 waits on B's value
      v = mk(32'h77000001, 32'h77000002, 1, 0, 1, 7'd7, 7'd7, 1, 1, 0, 0, 7'd0, 0, 3'b000, 3'd3, 3'd5);
      applyStimulus(v, 1'b1, 1'b0);
      checkReady("waw_a_ready", 1'b1);
      pushExp(32'h77000001, NO, 2'd1);
      step();
      checkOutput("waw_a_issue");
      v = mk(32'h77000003, 32'h0, 0, 0, 0, 7'd60, 7'd0, 0, 0, 7'd7, 3'b001, 7'd0, 0, 3'b000, 3'd0, 3'd0);
      applyStimulus(v, 1'b1, 1'b0);
      checkReady("waw_hold_ready", 1'b0);
      pushExp(NE, 32'h77000002, 2'd1);
      step();
      checkOutput("waw_b_issue");
      for (int k = 0; k < 5; k++) begin
         checkReady($sformatf("waw_reader_blocked%0d", k), 1'b0);
         pushExp(NE, NO, 2'd0);
         step();
         checkOutput($sformatf("waw_reader_stall%0d", k));
      end
      checkReady("waw_reader_ready", 1'b1);
      pushExp(32'h77000003, NO, 2'd1);
      step();
      checkOutput("waw_reader_issue");
      drain(8);

      // Async reset in the middle of a hold clears outputs, holding register and scoreboard
      v = mk(32'h1C000303, 32'h3C000400, 1, 0, 1, 7'd3, 7'd40, 1, 0, 0, 0, 7'd3, 0, 3'b001, 3'd4, 3'd0);
      applyStimulus(v, 1'b1, 1'b0);
      pushExp(32'h1C000303, NO, 2'd1);
      step();
      checkOutput("rst_a_issue");
      applyStimulus(idle, 1'b0, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      pushExp(NE, NO, 2'd0);
      checkOutput("rst_async_outputs");
      #2;
      reset = 1'b1;
      pushExp(NE, NO, 2'd0);
      step();
      checkOutput("rst_hold_cleared");
      v = mk(32'h5A5A5A5A, 32'h0, 0, 0, 0, 7'd61, 7'd0, 0, 0, 7'd3, 3'b001, 7'd0, 0, 3'b000, 3'd0, 3'd0);
      applyStimulus(v, 1'b1, 1'b0);
      checkReady("rst_sb_cleared", 1'b1);
      pushExp(32'h5A5A5A5A, NO, 2'd1);
      step();
      checkOutput("rst_reader_issue");
      drain(1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
